// File: rtl/util_axis_uart_rx_os_pkg.sv
`default_nettype none
// ============================================================================
// Module      : util_axis_uart_rx_os_pkg
// Description : Shared types and constants for the oversampling UART receiver.
//               Holds the receiver state encoding, the oversampling and vote
//               sample positions, the tuser flag positions and the baud
//               divisor helper.
// Revision    : 1.0 - initial release
// ============================================================================
package util_axis_uart_rx_os_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    localparam int         OS_RATE      = 16;
    localparam logic [3:0] VOTE_LO      = 4'd7;
    localparam logic [3:0] VOTE_MID     = 4'd8;
    localparam logic [3:0] VOTE_HI      = 4'd9;
    localparam int         TUSER_FRAME  = 0;
    localparam int         TUSER_PARITY = 1;

    // Rounded clocks-per-oversample-tick, never below one.
    function automatic int calc_divisor(input longint clk_hz, input longint baud);
        longint l_div;
        l_div = (clk_hz + baud * 8) / (baud * OS_RATE);
        return (l_div < 1) ? 1 : int'(l_div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/util_uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : util_uart_baud_tick
// Description : Divisor counter producing a one-cycle tick every DIVISOR
//               clocks while enabled. i_restart zeroes the phase so the first
//               tick lands DIVISOR clocks later.
// Ports       : clk, rst (async, active-high), i_enable, i_restart, o_tick
// Revision    : 1.0 - initial release
// ============================================================================
module util_uart_baud_tick #(
    parameter int DIVISOR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                 c_CNT_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIVISOR - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || !i_enable || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_tick = i_enable && !i_restart && (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/util_axis_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : util_axis_uart_rx_os
// Description : 16x oversampling UART receiver with AXI-Stream master output.
//               Each bit is decided by a 3-sample majority vote around the
//               bit centre; parity and framing errors are flagged on tuser.
// Ports       : aclk, arst (async, active-high), rx (serial in),
//               m_axis_tdata/tuser/tvalid/tready (word out, tuser[0]=frame
//               error, tuser[1]=parity error), overrun (dropped-frame pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module util_axis_uart_rx_os
    import util_axis_uart_rx_os_pkg::*;
#(
    parameter int BAUD_CLOCK_SPEED = 50000000,
    parameter int BAUD_RATE        = 115200,
    parameter bit PARITY_ENA       = 1'b0,
    parameter bit PARITY_TYPE      = 1'b0,
    parameter int STOP_BITS        = 1,
    parameter int DATA_BITS        = 8
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [1:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 overrun
);

    localparam int         c_DIVISOR   = calc_divisor(BAUD_CLOCK_SPEED, BAUD_RATE);
    localparam logic [3:0] c_OS_LAST   = 4'(OS_RATE - 1);
    localparam logic [2:0] c_IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic       c_STOP_LAST = 1'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2, r_hist;
    state_t               r_state, w_state_nxt;
    logic [3:0]           r_os_cnt;
    logic [2:0]           r_idx;
    logic                 r_stop_idx;
    logic                 r_s_lo, r_s_mid;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_frame_err, r_parity_err;
    logic [DATA_BITS-1:0] r_tdata;
    logic [1:0]           r_tuser;
    logic                 r_tvalid, r_overrun;

    logic w_fall, w_start, w_tick, w_vote, w_vote_tick, w_bit_end;
    logic w_frame_err_nxt, w_parity_err_nxt, w_frame_done;

    // rx is asynchronous: two flops for metastability, one more as edge history.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_fall  = r_hist & ~r_sync2;
    assign w_start = (r_state == IDLE) & w_fall;

    util_uart_baud_tick #(
        .DIVISOR (c_DIVISOR)
    ) u_baud_tick (
        .clk       (aclk),
        .rst       (arst),
        .i_enable  (r_state != IDLE),
        .i_restart (w_start),
        .o_tick    (w_tick)
    );

    // Third vote sample is taken live on the deciding tick.
    assign w_vote           = (r_s_lo & r_s_mid) | (r_s_lo & r_sync2) | (r_s_mid & r_sync2);
    assign w_vote_tick      = w_tick && (r_os_cnt == VOTE_HI);
    assign w_bit_end        = w_tick && (r_os_cnt == c_OS_LAST);
    assign w_frame_err_nxt  = r_frame_err | ~w_vote;
    assign w_parity_err_nxt = ((^r_data) ^ w_vote) != PARITY_TYPE;
    // Frame ends at the last stop vote, not at the bit end, so a start edge
    // arriving right after a short stop bit is still caught.
    assign w_frame_done     = w_vote_tick && (r_state == STOP) && (r_stop_idx == c_STOP_LAST);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                if (w_vote_tick && w_vote) w_state_nxt = IDLE;
                else if (w_bit_end)        w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end && (r_idx == c_IDX_LAST))
                    w_state_nxt = PARITY_ENA ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                // All-zero data with a low stop bit is a line break: hold off
                // until the line returns high so only one word is produced.
                if (w_frame_done)
                    w_state_nxt = ((r_data == '0) && w_frame_err_nxt) ? BREAK_WAIT : IDLE;
            end
            BREAK_WAIT: begin
                if (r_sync2) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_os_cnt     <= '0;
            r_idx        <= '0;
            r_stop_idx   <= 1'b0;
            r_s_lo       <= 1'b1;
            r_s_mid      <= 1'b1;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_start) begin
            r_os_cnt     <= '0;
            r_idx        <= '0;
            r_stop_idx   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 4'd1;
            if (r_os_cnt == VOTE_LO)  r_s_lo  <= r_sync2;
            if (r_os_cnt == VOTE_MID) r_s_mid <= r_sync2;
            if (r_os_cnt == VOTE_HI) begin
                case (r_state)
                    // LSB first: after DATA_BITS shifts the word is LSB-aligned.
                    DATA:    r_data       <= {w_vote, r_data[DATA_BITS-1:1]};
                    PARITY:  r_parity_err <= PARITY_ENA && w_parity_err_nxt;
                    STOP:    r_frame_err  <= w_frame_err_nxt;
                    default: ;
                endcase
            end
            if (r_os_cnt == c_OS_LAST) begin
                if (r_state == DATA) r_idx      <= r_idx + 3'd1;
                if (r_state == STOP) r_stop_idx <= r_stop_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                if (!r_tvalid || m_axis_tready) begin
                    r_tdata               <= r_data;
                    r_tuser[TUSER_FRAME]  <= w_frame_err_nxt;
                    r_tuser[TUSER_PARITY] <= PARITY_ENA ? r_parity_err : 1'b0;
                    r_tvalid              <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_util_axis_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_util_axis_uart_rx_os
// Description : Self-checking bench for util_axis_uart_rx_os. Instance A is
//               8N1, instance B is 8E1; both run at 32 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_util_axis_uart_rx_os;

    localparam int BIT_CLKS = 32;

    logic tb_data_clk = 1'b0;
    always #5 tb_data_clk = ~tb_data_clk;

    logic       arst, rx_a, rx_b, tready;
    logic [7:0] tdata_a, tdata_b;
    logic [1:0] tuser_a, tuser_b;
    logic       tvalid_a, tvalid_b, overrun_a, overrun_b;

    util_axis_uart_rx_os #(
        .BAUD_CLOCK_SPEED(50000000), .BAUD_RATE(1562500), .PARITY_ENA(1'b0),
        .PARITY_TYPE(1'b0), .STOP_BITS(1), .DATA_BITS(8)
    ) u_dut_a (
        .aclk(tb_data_clk), .arst(arst), .rx(rx_a),
        .m_axis_tdata(tdata_a), .m_axis_tuser(tuser_a), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(tready), .overrun(overrun_a)
    );

    util_axis_uart_rx_os #(
        .BAUD_CLOCK_SPEED(50000000), .BAUD_RATE(1562500), .PARITY_ENA(1'b1),
        .PARITY_TYPE(1'b0), .STOP_BITS(1), .DATA_BITS(8)
    ) u_dut_b (
        .aclk(tb_data_clk), .arst(arst), .rx(rx_b),
        .m_axis_tdata(tdata_b), .m_axis_tuser(tuser_b), .m_axis_tvalid(tvalid_b),
        .m_axis_tready(tready), .overrun(overrun_b)
    );

    // Monitor: words handed over, overrun pulses, cycle of last tvalid rise.
    int         cyc = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int         ovr_a = 0, ovr_b = 0, rise_a = 0, rise_b = 0;
    logic       prev_va = 1'b0, prev_vb = 1'b0;

    always @(posedge tb_data_clk) cyc <= cyc + 1;

    always @(negedge tb_data_clk) begin
        if (tvalid_a && tready) q_a.push_back({tuser_a, tdata_a});
        if (tvalid_b && tready) q_b.push_back({tuser_b, tdata_b});
        if (overrun_a) ovr_a++;
        if (overrun_b) ovr_b++;
        if (tvalid_a && !prev_va) rise_a = cyc;
        if (tvalid_b && !prev_vb) rise_b = cyc;
        prev_va = tvalid_a;
        prev_vb = tvalid_b;
    end

    int n_total = 0, n_bad = 0;
    int fall_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge tb_data_clk);
        #1;
    endtask

    task automatic set_rx(input int ch, input logic v);
        if (ch == 0) rx_a = v;
        else         rx_b = v;
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        set_rx(ch, 1'b0);
        fall_cyc = cyc;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            set_rx(ch, d[i]);
            step(BIT_CLKS);
        end
        if (has_par) begin
            set_rx(ch, par);
            step(BIT_CLKS);
        end
        set_rx(ch, stop);
        step(BIT_CLKS);
        set_rx(ch, 1'b1);
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        bit         has_par;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic [1:0] exp_user;
    } vec_t;

    vec_t       vecs[9];
    int         base, got_n, lat, lo, hi, ovr0;
    logic [9:0] w;

    initial begin
        vecs[0] = '{0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 2'b00};
        vecs[1] = '{0, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 2'b00};
        vecs[2] = '{1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 2'b10};
        vecs[3] = '{1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 2'b00};
        vecs[4] = '{0, 8'hA3, 1'b0, 1'b0, 1'b0, 8'hA3, 2'b01};
        vecs[5] = '{1, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 2'b00};
        vecs[6] = '{1, 8'hA3, 1'b1, 1'b0, 1'b0, 8'hA3, 2'b01};
        vecs[7] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b00};
        vecs[8] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00};

        arst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; tready = 1'b0;
        step(3);
        check("reset_a", {20'd0, tvalid_a, overrun_a, tuser_a, tdata_a}, 32'd0);
        check("reset_b", {20'd0, tvalid_b, overrun_b, tuser_b, tdata_b}, 32'd0);
        arst = 1'b0;
        step(5);

        // Glitch shorter than the vote window must produce nothing.
        tready = 1'b1;
        base = q_a.size(); ovr0 = ovr_a;
        rx_a = 1'b0; step(6); rx_a = 1'b1;
        step(3 * BIT_CLKS);
        check("glitch_words", q_a.size() - base, 0);
        check("glitch_overrun", ovr_a - ovr0, 0);
        check("glitch_tvalid", {31'd0, tvalid_a}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            base = (vecs[i].ch == 0) ? q_a.size() : q_b.size();
            send_frame(vecs[i].ch, vecs[i].data, vecs[i].has_par, vecs[i].par, vecs[i].stop);
            step(2 * BIT_CLKS);
            lo = BIT_CLKS * (9 + int'(vecs[i].has_par)) + BIT_CLKS / 2 + 1;
            hi = BIT_CLKS * (10 + int'(vecs[i].has_par));
            w = 'x;
            if (vecs[i].ch == 0) begin
                got_n = q_a.size() - base;
                if (got_n > 0) w = q_a[base];
                lat = rise_a - fall_cyc;
            end else begin
                got_n = q_b.size() - base;
                if (got_n > 0) w = q_b[base];
                lat = rise_b - fall_cyc;
            end
            check($sformatf("vec%0d_count", i), got_n, 1);
            check($sformatf("vec%0d_word", i), {22'd0, w}, {22'd0, vecs[i].exp_user, vecs[i].exp_data});
            check($sformatf("vec%0d_latency_ok(lat=%0d)", i, lat), {31'd0, (lat >= lo && lat <= hi)}, 32'd1);
        end

        // Line break: exactly one zero word with frame error.
        base = q_a.size();
        rx_a = 1'b0; step(20 * BIT_CLKS); rx_a = 1'b1;
        step(4 * BIT_CLKS);
        check("break_count", q_a.size() - base, 1);
        w = (q_a.size() > base) ? q_a[base] : 'x;
        check("break_word", {22'd0, w}, {22'd0, 2'b01, 8'h00});
        base = q_a.size();
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("post_break_count", q_a.size() - base, 1);
        w = (q_a.size() > base) ? q_a[base] : 'x;
        check("post_break_word", {22'd0, w}, {22'd0, 2'b00, 8'h33});

        // Backpressure: second frame is dropped with one overrun pulse.
        tready = 1'b0;
        base = q_a.size(); ovr0 = ovr_a;
        send_frame(0, 8'h41, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("bp_first_valid", {23'd0, tvalid_a, tdata_a}, {23'd0, 1'b1, 8'h41});
        check("bp_first_overrun", ovr_a - ovr0, 0);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("bp_hold", {21'd0, tvalid_a, tuser_a, tdata_a}, {21'd0, 1'b1, 2'b00, 8'h41});
        check("bp_overrun_pulses", ovr_a - ovr0, 1);
        tready = 1'b1;
        step(6 * BIT_CLKS);
        check("bp_accept_count", q_a.size() - base, 1);
        w = (q_a.size() > base) ? q_a[base] : 'x;
        check("bp_accept_word", {22'd0, w}, {22'd0, 2'b00, 8'h41});
        check("bp_tvalid_low", {31'd0, tvalid_a}, 32'd0);

        // Reset in the middle of data bit 3 while a word is pending.
        tready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("pre_reset_valid", {31'd0, tvalid_a}, 32'd1);
        rx_a = 1'b0; step(BIT_CLKS);
        rx_a = 1'b0; step(BIT_CLKS);
        rx_a = 1'b1; step(BIT_CLKS);
        rx_a = 1'b1; step(BIT_CLKS);
        rx_a = 1'b1; step(BIT_CLKS / 2);
        arst = 1'b1;
        #2;
        check("async_reset_out", {21'd0, tvalid_a, tuser_a, tdata_a}, 32'd0);
        rx_a = 1'b1;
        step(10);
        arst = 1'b0;
        step(2 * BIT_CLKS);
        tready = 1'b1;
        base = q_a.size();
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("after_reset_count", q_a.size() - base, 1);
        w = (q_a.size() > base) ? q_a[base] : 'x;
        check("after_reset_word", {22'd0, w}, {22'd0, 2'b00, 8'h7E});

        // Back-to-back incrementing stream, as from a transmit core.
        base = q_a.size();
        for (int k = 0; k < 8; k++) send_frame(0, 8'h41 + 8'(k), 1'b0, 1'b0, 1'b1);
        step(2 * BIT_CLKS);
        check("loop_count", q_a.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            w = (q_a.size() > base + k) ? q_a[base + k] : 'x;
            check($sformatf("loop_word%0d", k), {22'd0, w}, {22'd0, 2'b00, 8'h41 + 8'(k)});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
